// File: rtl/krnl_partialknn_local_mem_1r1w_init.sv
// -----------------------------------------------------------------------------
// krnl_partialknn_local_mem_1r1w_init
//
// Simple-dual-port (one read, one write) local buffer for the partialKnn
// kernels. The storage is a plain array so synthesis can map it onto URAM.
// After reset, or on a clear pulse, a hardware sweep writes zero to every word.
// Accesses are accepted only after the sweep has finished.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (flushes the read pipeline and
//              restarts the zero sweep)
//   clear      single-cycle pulse in RUN: restart the zero sweep
//   init_done  high while the block accepts accesses
//   address0   read address
//   ce0        read request
//   q0         read data, ReadLatency cycles after the request
//   q0_valid   q0 carries data for a request
//   address1   write address
//   ce1        write request
//   we1        byte write enables; bit i covers d1[8i+7:8i]
//   d1         write data
//   addr_err   sticky: an out-of-range access was seen (cleared only by reset)
// -----------------------------------------------------------------------------
module krnl_partialknn_local_mem_1r1w_init #(
    parameter int DataWidth    = 256,
    parameter int AddressRange = 2048,
    parameter int AddressWidth = 11,
    parameter int ReadLatency  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    output logic                      init_done,
    input  logic [AddressWidth-1:0]   address0,
    input  logic                      ce0,
    output logic [DataWidth-1:0]      q0,
    output logic                      q0_valid,
    input  logic [AddressWidth-1:0]   address1,
    input  logic                      ce1,
    input  logic [DataWidth/8-1:0]    we1,
    input  logic [DataWidth-1:0]      d1,
    output logic                      addr_err
);

    localparam int ByteCnt = DataWidth / 8;
    localparam int IdxW    = (AddressRange > 1) ? $clog2(AddressRange) : 1;

    // Last index of the zero sweep.
    localparam logic [IdxW-1:0] LastIdx = IdxW'(AddressRange - 1);

    // One extra bit so AddressRange itself is representable even when it
    // equals 2**AddressWidth.
    localparam logic [AddressWidth:0] RangeLim = (AddressWidth + 1)'(AddressRange);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Merge a write into an existing word: enabled bytes take the new data.
    // Used for write-to-read forwarding on a same-address collision.
    function automatic logic [DataWidth-1:0] byte_merge(
        input logic [DataWidth-1:0] old_word,
        input logic [DataWidth-1:0] new_word,
        input logic [ByteCnt-1:0]   be
    );
        logic [DataWidth-1:0] res;
        res = old_word;
        for (int b = 0; b < ByteCnt; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Storage: intentionally not reset so it maps to URAM/BRAM.
    logic [DataWidth-1:0] mem_r [0:AddressRange-1];

    state_t          state_r;
    state_t          state_s;
    logic [IdxW-1:0] cnt_r;
    logic [IdxW-1:0] cnt_s;
    logic            init_done_r;
    logic            addr_err_r;

    logic                 vld_r [0:ReadLatency-1];
    logic [DataWidth-1:0] dat_r [0:ReadLatency-1];

    logic                 rd_in_range_s;
    logic                 wr_in_range_s;
    logic                 rd_issue_s;
    logic                 wr_en_s;
    logic                 wr_hit_s;
    logic                 sweep_s;
    logic                 err_set_s;
    logic [IdxW-1:0]      rd_idx_s;
    logic [IdxW-1:0]      wr_idx_s;
    logic [DataWidth-1:0] rd_raw_s;
    logic [DataWidth-1:0] rd_data_s;

    // Address decode, access qualification and forwarded read data.
    always_comb begin
        rd_in_range_s = ({1'b0, address0} < RangeLim);
        wr_in_range_s = ({1'b0, address1} < RangeLim);
        rd_idx_s      = address0[IdxW-1:0];
        wr_idx_s      = address1[IdxW-1:0];
        sweep_s       = (state_r == ST_INIT);
        rd_issue_s    = (state_r == ST_RUN) && ce0;
        wr_en_s       = (state_r == ST_RUN) && ce1 && wr_in_range_s;
        wr_hit_s      = wr_en_s && (address0 == address1);
        err_set_s     = (state_r == ST_RUN) &&
                        ((ce0 && !rd_in_range_s) || (ce1 && !wr_in_range_s));
        rd_raw_s      = mem_r[rd_idx_s];
        if (!rd_in_range_s) begin
            rd_data_s = {DataWidth{1'b0}};
        end else if (wr_hit_s) begin
            // Write-first: bytes being written this cycle come from d1.
            rd_data_s = byte_merge(rd_raw_s, d1, we1);
        end else begin
            rd_data_s = rd_raw_s;
        end
    end

    // Next-state logic for the INIT/RUN controller and the sweep counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == LastIdx) begin
                    state_s = ST_RUN;
                    cnt_s   = {IdxW{1'b0}};
                end else begin
                    state_s = ST_INIT;
                    cnt_s   = cnt_r + {{(IdxW-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_s = ST_INIT;
                    cnt_s   = {IdxW{1'b0}};
                end else begin
                    state_s = ST_RUN;
                    cnt_s   = cnt_r;
                end
            end
            default: begin
                state_s = ST_INIT;
                cnt_s   = {IdxW{1'b0}};
            end
        endcase
    end

    // Controller state, sweep counter and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_INIT;
            cnt_r       <= {IdxW{1'b0}};
            init_done_r <= 1'b0;
            addr_err_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            init_done_r <= (state_s == ST_RUN);
            if (err_set_s) begin
                addr_err_r <= 1'b1;
            end
        end
    end

    // Memory write port: zero sweep during INIT, byte-enabled writes in RUN.
    always_ff @(posedge clk) begin
        if (sweep_s) begin
            mem_r[cnt_r] <= {DataWidth{1'b0}};
        end else if (wr_en_s) begin
            for (int b = 0; b < ByteCnt; b++) begin
                if (we1[b]) begin
                    mem_r[wr_idx_s][8*b +: 8] <= d1[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 captures the array at issue; data registers
    // advance only with a valid entry so q0 holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < ReadLatency; k++) begin
                vld_r[k] <= 1'b0;
                dat_r[k] <= {DataWidth{1'b0}};
            end
        end else begin
            vld_r[0] <= rd_issue_s;
            if (rd_issue_s) begin
                dat_r[0] <= rd_data_s;
            end
            for (int k = 1; k < ReadLatency; k++) begin
                vld_r[k] <= vld_r[k-1];
                if (vld_r[k-1]) begin
                    dat_r[k] <= dat_r[k-1];
                end
            end
        end
    end

    assign q0        = dat_r[ReadLatency-1];
    assign q0_valid  = vld_r[ReadLatency-1];
    assign init_done = init_done_r;
    assign addr_err  = addr_err_r;

endmodule

// File: tb/tb_krnl_partialknn_local_mem_1r1w_init.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for krnl_partialknn_local_mem_1r1w_init.
// AddressWidth is widened to 12 so that out-of-range addresses (3000, 2050)
// can actually be presented on the ports.
// -----------------------------------------------------------------------------
module tb_krnl_partialknn_local_mem_1r1w_init;

    localparam int DW = 256;
    localparam int AR = 2048;
    localparam int AW = 12;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          init_done;
    logic [AW-1:0] address0;
    logic          ce0;
    logic [DW-1:0] q0;
    logic          q0_valid;
    logic [AW-1:0] address1;
    logic          ce1;
    logic [DW/8-1:0] we1;
    logic [DW-1:0] d1;
    logic          addr_err;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    krnl_partialknn_local_mem_1r1w_init #(
        .DataWidth   (DW),
        .AddressRange(AR),
        .AddressWidth(AW),
        .ReadLatency (RL)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .init_done(init_done),
        .address0 (address0),
        .ce0      (ce0),
        .q0       (q0),
        .q0_valid (q0_valid),
        .address1 (address1),
        .ce1      (ce1),
        .we1      (we1),
        .d1       (d1),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW/8-1:0] be, input logic [DW-1:0] d);
        address1 = a;
        we1      = be;
        d1       = d;
        ce1      = 1'b1;
        tick();
        ce1      = 1'b0;
        we1      = '0;
    endtask

    // Single read: no valid after one edge, valid plus data after two.
    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        address0 = a;
        ce0      = 1'b1;
        tick();
        ce0      = 1'b0;
        chk({tag, "_v_early"}, {255'd0, q0_valid}, 256'd0);
        tick();
        chk({tag, "_valid"}, {255'd0, q0_valid}, 256'd1);
        chk({tag, "_data"}, q0, exp);
    endtask

    // Counts edges until init_done, also noting any q0_valid seen meanwhile.
    task automatic wait_init(output int n, output int vld_seen);
        n        = 0;
        vld_seen = 0;
        while (!init_done && n < 3000) begin
            tick();
            n++;
            if (q0_valid) vld_seen++;
        end
    endtask

    logic [DW-1:0] coll_exp;
    logic [DW-1:0] fill;
    logic [7:0]    bv;
    int            n_cyc;
    int            n_vld;

    initial begin
        reset_n  = 1'b0;
        clear    = 1'b0;
        address0 = '0;
        ce0      = 1'b0;
        address1 = '0;
        ce1      = 1'b0;
        we1      = '0;
        d1       = '0;
        coll_exp = {{28{8'h11}}, {4{8'hFF}}};

        // Reset state
        tick();
        tick();
        chk("rst_init_done", {255'd0, init_done}, 256'd0);
        chk("rst_q0_valid", {255'd0, q0_valid}, 256'd0);
        chk("rst_q0", q0, 256'd0);
        chk("rst_addr_err", {255'd0, addr_err}, 256'd0);

        // Sweep after reset release lasts exactly AR cycles
        reset_n = 1'b1;
        wait_init(n_cyc, n_vld);
        chk("init_cycles", 256'(n_cyc), 256'd2048);

        rd_chk("rd0", 12'd0, 256'd0);
        rd_chk("rd1023", 12'd1023, 256'd0);
        rd_chk("rd2047", 12'd2047, 256'd0);

        // Full-word write then read
        wr(12'd5, {32{1'b1}}, {32{8'hA5}});
        rd_chk("rd5_a5", 12'd5, {32{8'hA5}});
        tick();
        chk("hold_q0", q0, {32{8'hA5}});

        // Fill 0..7 with distinct bytes, then back-to-back reads
        for (int i = 0; i < 8; i++) begin
            bv = 8'h10 + 8'(i);
            wr(12'(i), {32{1'b1}}, {32{bv}});
        end
        for (int i = 0; i < 8; i++) begin
            address0 = 12'(i);
            ce0      = 1'b1;
            tick();
            if (i >= 1) begin
                bv = 8'h10 + 8'(i - 1);
                chk("b2b_valid", {255'd0, q0_valid}, 256'd1);
                chk("b2b_data", q0, {32{bv}});
            end
        end
        ce0 = 1'b0;
        tick();
        chk("b2b_last_valid", {255'd0, q0_valid}, 256'd1);
        chk("b2b_last_data", q0, {32{8'h17}});
        tick();
        chk("b2b_end_valid", {255'd0, q0_valid}, 256'd0);
        chk("b2b_end_hold", q0, {32{8'h17}});

        // Same-cycle collision, write-first per byte
        wr(12'd9, {32{1'b1}}, {32{8'h11}});
        address0 = 12'd9;
        ce0      = 1'b1;
        address1 = 12'd9;
        we1      = 32'h0000_000F;
        d1       = {32{8'hFF}};
        ce1      = 1'b1;
        tick();
        ce0 = 1'b0;
        ce1 = 1'b0;
        we1 = '0;
        tick();
        chk("coll_valid", {255'd0, q0_valid}, 256'd1);
        chk("coll_data", q0, coll_exp);
        rd_chk("coll_mem", 12'd9, coll_exp);

        // Out-of-range accesses
        chk("err_before", {255'd0, addr_err}, 256'd0);
        rd_chk("rd3000", 12'd3000, 256'd0);
        chk("err_after_rd", {255'd0, addr_err}, 256'd1);
        wr(12'd2050, {32{1'b1}}, {32{8'hEE}});
        chk("err_after_wr", {255'd0, addr_err}, 256'd1);
        rd_chk("rd2047_kept", 12'd2047, 256'd0);
        rd_chk("rd2_kept", 12'd2, {32{8'h12}});
        chk("err_sticky", {255'd0, addr_err}, 256'd1);

        // Clear re-zeroes the memory; reads are ignored during the sweep
        wr(12'd7, {32{1'b1}}, {32{8'h3C}});
        rd_chk("rd7_3c", 12'd7, {32{8'h3C}});
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_init_low", {255'd0, init_done}, 256'd0);
        address0 = 12'd7;
        ce0      = 1'b1;
        wait_init(n_cyc, n_vld);
        ce0 = 1'b0;
        chk("clr_cycles", 256'(n_cyc), 256'd2048);
        chk("clr_no_valid", 256'(n_vld), 256'd0);
        tick();
        chk("clr_no_late_valid", {255'd0, q0_valid}, 256'd0);
        chk("clr_err_kept", {255'd0, addr_err}, 256'd1);
        rd_chk("rd7_zero", 12'd7, 256'd0);

        // Reset with reads in flight
        rd_chk("rd9_pre", 12'd9, 256'd0);
        wr(12'd9, {32{1'b1}}, {32{8'h5A}});
        address0 = 12'd9;
        ce0      = 1'b1;
        tick();
        address0 = 12'd8;
        tick();
        ce0 = 1'b0;
        chk("pre_rst_valid", {255'd0, q0_valid}, 256'd1);
        chk("pre_rst_data", q0, {32{8'h5A}});
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {255'd0, q0_valid}, 256'd0);
        chk("arst_q0", q0, 256'd0);
        chk("arst_init_done", {255'd0, init_done}, 256'd0);
        chk("arst_addr_err", {255'd0, addr_err}, 256'd0);
        tick();
        tick();
        reset_n = 1'b1;
        wait_init(n_cyc, n_vld);
        chk("rst2_cycles", 256'(n_cyc), 256'd2048);
        chk("rst2_no_valid", 256'(n_vld), 256'd0);
        rd_chk("rd9_after_rst", 12'd9, 256'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
